// File: rtl/booth4_mul_seq_pkg.sv
// booth4_pkg: shared types for the radix-4 Booth multiplier.
//   state_t     - controller states (IDLE, EXEC, DONE)
//   booth_op_t  - partial-product selection (ZERO, PA, P2A, M2A, MA)
//   booth_decode- maps a Booth triple {x1, x0, x-1} to a booth_op_t
package booth4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PA   = 3'd1,
    P2A  = 3'd2,
    M2A  = 3'd3,
    MA   = 3'd4
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic [2:0] triple);
    case (triple)
      3'b001, 3'b010: return PA;
      3'b011:         return P2A;
      3'b100:         return M2A;
      3'b101, 3'b110: return MA;
      default:        return ZERO;  // 000 / 111
    endcase
  endfunction

endpackage

// File: rtl/booth4_mul_seq_if.sv
// booth4_mul_seq_if: start/done handshake bundle of the Booth multiplier.
//   master (operand-select side): drives start, op_signed, multiplicand_a,
//     multiplier_x (and clear when BOOTH4_CLEAR_EN is defined);
//     receives busy, done, result.
//   slave (multiplier side): the mirror image.
// Optional feature macro: BOOTH4_CLEAR_EN adds the synchronous clear abort.
interface booth4_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 op_signed;
  logic [WIDTH-1:0]     multiplicand_a;
  logic [WIDTH-1:0]     multiplier_x;
`ifdef BOOTH4_CLEAR_EN
  logic                 clear;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, op_signed, multiplicand_a, multiplier_x,
`ifdef BOOTH4_CLEAR_EN
    output clear,
`endif
    input  busy, done, result
  );

  modport slave (
    input  start, op_signed, multiplicand_a, multiplier_x,
`ifdef BOOTH4_CLEAR_EN
    input  clear,
`endif
    output busy, done, result
  );
endinterface

// File: rtl/booth4_mul_seq_pp_sel.sv
// booth4_pp_sel: combinational radix-4 Booth partial-product selector.
//   triple [2:0]      - {x[1], x[0], previous x[1]}
//   a      [WIDTH+1:0]- extended multiplicand
//   pp     [WIDTH+1:0]- selected partial product (0, +A, +2A, -2A, -A),
//                       modulo 2^(WIDTH+2)
module booth4_pp_sel
  import booth4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       triple,
  input  logic [WIDTH+1:0] a,
  output logic [WIDTH+1:0] pp
);
  localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

  logic [WIDTH+1:0] a2;

  // 2A drops the top bit; the extended operand always has headroom for it.
  assign a2 = {a[WIDTH:0], 1'b0};

  always_comb begin
    pp = '0;
    case (booth_decode(triple))
      PA:      pp = a;
      P2A:     pp = a2;
      M2A:     pp = ~a2 + ONE;
      MA:      pp = ~a + ONE;
      default: pp = '0;
    endcase
  end
endmodule

// File: rtl/booth4_mul_seq.sv
// booth4_mul_seq: sequential radix-4 Booth multiplier, two multiplier bits
// retired per cycle, WIDTH/2+1 iterations per product in both modes.
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - booth4_mul_seq_if.slave: start, op_signed, multiplicand_a,
//           multiplier_x in; busy, done (1-cycle pulse), result out
// Optional feature macro: BOOTH4_CLEAR_EN (clear aborts to IDLE, keeps result).
module booth4_mul_seq
  import booth4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  booth4_mul_seq_if.slave     bus
);
  localparam int EW = WIDTH + 2;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               state_reg;
  logic [CW-1:0]        count_reg;
  logic [EW-1:0]        u_reg;
  logic [EW-1:0]        v_reg;
  logic [EW-1:0]        a_reg;
  logic [EW-1:0]        x_reg;
  logic                 fbi_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2*WIDTH-1:0]   result_reg;

  logic [EW-1:0]        pp;
  logic [EW-1:0]        u_sum;
  logic [2*EW-1:0]      p_next;
  logic [EW-1:0]        a_ext;
  logic [EW-1:0]        x_ext;

  booth4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .triple ({x_reg[1:0], fbi_reg}),
    .a      (a_reg),
    .pp     (pp)
  );

  assign u_sum  = u_reg + pp;
  // After N double-shifts P holds the exact product, so no final correction.
  assign p_next = $signed({u_sum, v_reg}) >>> 2;

  assign a_ext = bus.op_signed ? {{2{bus.multiplicand_a[WIDTH-1]}}, bus.multiplicand_a}
                               : {2'b00, bus.multiplicand_a};
  assign x_ext = bus.op_signed ? {{2{bus.multiplier_x[WIDTH-1]}}, bus.multiplier_x}
                               : {2'b00, bus.multiplier_x};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      u_reg      <= '0;
      v_reg      <= '0;
      a_reg      <= '0;
      x_reg      <= '0;
      fbi_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end
`ifdef BOOTH4_CLEAR_EN
    else if (bus.clear) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end
`endif
    else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg     <= a_ext;
            x_reg     <= x_ext;
            u_reg     <= '0;
            v_reg     <= '0;
            fbi_reg   <= 1'b0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end else begin
            state_reg <= IDLE;
          end
        end
        EXEC: begin
          u_reg     <= p_next[2*EW-1:EW];
          v_reg     <= p_next[EW-1:0];
          fbi_reg   <= x_reg[1];
          x_reg     <= $signed(x_reg) >>> 2;
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            result_reg <= p_next[2*WIDTH-1:0];
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
endmodule
